// File: rtl/prach_hb1_interp_ch.sv
// ---------------------------------------------------------------------------
// prach_hb1_interp_ch
// 2x half-band interpolator, time-multiplexed over up to NUM_CHANNEL channels.
// Each valid input sample of a channel produces one polyphase output pair:
//   dout_dp1 - centre-tap phase, the channel's previous sample x[n-1], unscaled
//   dout_dp2 - filtered phase, sat16((c0*(x0+x3) + c1*(x1+x2) + 2^15) >>> 16)
// Each channel keeps its own 3-deep sample history. All control fields travel
// alongside the data through a fixed 4-register pipeline.
//
// Ports
//   clk       in   single clock
//   rst_n     in   asynchronous active-low reset
//   din_dq    in   16b signed sample, fi(1,16,15)
//   din_dv    in   input sample valid
//   din_chn   in   8b channel tag (low bits select the history slot)
//   sync_in   in   frame sync, carried along with the data
//   dout_dp1  out  16b centre phase
//   dout_dp2  out  16b filtered phase, rounded and saturated
//   dout_dv   out  output pair valid (din_dv delayed by LATENCY)
//   dout_chn  out  8b channel tag, all bits carried through
//   sync_out  out  sync_in delayed by LATENCY
// ---------------------------------------------------------------------------
module prach_hb1_interp_ch #(
    parameter int NUM_CHANNEL = 16,
    // Pipeline depth; the datapath below is built for exactly 4 stages.
    parameter int LATENCY     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] din_dq,
    input  logic               din_dv,
    input  logic        [7:0]  din_chn,
    input  logic               sync_in,
    output logic signed [15:0] dout_dp1,
    output logic signed [15:0] dout_dp2,
    output logic               dout_dv,
    output logic        [7:0]  dout_chn,
    output logic               sync_out
);

    localparam int CW = $clog2(NUM_CHANNEL);

    // Half-band even-phase taps, fi(1,18,17)
    localparam logic signed [17:0] C0  = -18'sd4134;
    localparam logic signed [17:0] C1  =  18'sd36901;
    // Half-LSB of the >>>16 result, for round-half-up
    localparam logic signed [35:0] RND =  36'sd32768;

    // -----------------------------------------------------------------------
    // Per-channel history: hist[ch][0] = x1, [1] = x2, [2] = x3
    // -----------------------------------------------------------------------
    logic [2:0][15:0] hist [NUM_CHANNEL];
    logic [CW-1:0]    idx;
    logic [2:0][15:0] cur;

    // Tags above NUM_CHANNEL-1 alias onto the low bits.
    assign idx = din_chn[CW-1:0];
    assign cur = hist[idx];

    // The read above is combinational from the registered array, so a write
    // at this edge is seen by a same-channel sample on the very next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHANNEL; i++) hist[i] <= '0;
        end else if (din_dv) begin
            hist[idx] <= {cur[1], cur[0], din_dq};
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: symmetric presums (17b, cannot overflow)
    // -----------------------------------------------------------------------
    logic signed [16:0] a1, b1;
    logic signed [15:0] d1_1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1   <= '0;
            b1   <= '0;
            d1_1 <= '0;
        end else begin
            a1   <= {din_dq[15], din_dq} + {cur[2][15], cur[2]};
            b1   <= {cur[0][15], cur[0]} + {cur[1][15], cur[1]};
            d1_1 <= cur[0];
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: products, 17b x 18b -> 35b
    // -----------------------------------------------------------------------
    logic signed [34:0] pa2, pb2;
    logic signed [15:0] d1_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pa2  <= '0;
            pb2  <= '0;
            d1_2 <= '0;
        end else begin
            pa2  <= 35'(a1) * 35'(C0);
            pb2  <= 35'(b1) * 35'(C1);
            d1_2 <= d1_1;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 3: sum plus rounding constant; 36b holds the worst case exactly
    // -----------------------------------------------------------------------
    logic signed [35:0] s3;
    logic signed [15:0] d1_3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3   <= '0;
            d1_3 <= '0;
        end else begin
            s3   <= 36'(pa2) + 36'(pb2) + RND;
            d1_3 <= d1_2;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 4: take bits [35:16] (>>>16 folds in the x2 interpolation gain)
    // and clip to 16b
    // -----------------------------------------------------------------------
    logic signed [19:0] q;
    logic signed [15:0] q_sat;

    assign q = s3[35:16];

    always_comb begin
        q_sat = q[15:0];
        if (q > 20'sd32767)
            q_sat = 16'sh7fff;
        else if (q < -20'sd32768)
            q_sat = 16'sh8000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_dp1 <= '0;
            dout_dp2 <= '0;
        end else begin
            dout_dp1 <= d1_3;
            dout_dp2 <= q_sat;
        end
    end

    // -----------------------------------------------------------------------
    // Control side-band: valid, tag and sync shifted alongside the data
    // -----------------------------------------------------------------------
    logic [LATENCY:1]       vld_pipe;
    logic [LATENCY:1]       sync_pipe;
    logic [LATENCY:1][7:0]  chn_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            sync_pipe <= '0;
            chn_pipe  <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[LATENCY-1:1], din_dv};
            sync_pipe <= {sync_pipe[LATENCY-1:1], sync_in};
            chn_pipe  <= {chn_pipe[LATENCY-1:1], din_chn};
        end
    end

    assign dout_dv  = vld_pipe[LATENCY];
    assign sync_out = sync_pipe[LATENCY];
    assign dout_chn = chn_pipe[LATENCY];

endmodule

// File: tb/tb_prach_hb1_interp_ch.sv
// ---------------------------------------------------------------------------
// tb_prach_hb1_interp_ch
// Scoreboard bench: every driven valid sample pushes its expected output
// pair (from the directed tables or a reference model) onto a queue; the
// monitor pops and compares whenever dout_dv is seen. dout_dv and sync_out
// are checked every cycle against the inputs delayed by 4.
// ---------------------------------------------------------------------------
module tb_prach_hb1_interp_ch;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] din_dq;
    logic               din_dv;
    logic        [7:0]  din_chn;
    logic               sync_in;
    logic signed [15:0] dout_dp1;
    logic signed [15:0] dout_dp2;
    logic               dout_dv;
    logic        [7:0]  dout_chn;
    logic               sync_out;

    prach_hb1_interp_ch dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din_dq   (din_dq),
        .din_dv   (din_dv),
        .din_chn  (din_chn),
        .sync_in  (sync_in),
        .dout_dp1 (dout_dp1),
        .dout_dp2 (dout_dp2),
        .dout_dv  (dout_dv),
        .dout_chn (dout_chn),
        .sync_out (sync_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] chn;
        int         dp1;
        int         dp2;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tst = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   mh [16][3];      // reference history: [0]=x1 [1]=x2 [2]=x3
    logic [3:0] dv_sr, sy_sr;

    // Directed tables
    int imp_x  [5] = '{16384, 0, 0, 0, 0};
    int imp_p1 [5] = '{0, 16384, 0, 0, 0};
    int imp_p2 [5] = '{-1033, 9225, 9225, -1033, 0};

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tst++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_dp2(int x0, int x1, int x2, int x3);
        longint v;
        v = -64'sd4134 * (longint'(x0) + x3) + 64'sd36901 * (longint'(x1) + x2) + 32768;
        v = v >>> 16;
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return int'(v);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_sr <= '0;
            sy_sr <= '0;
        end else begin
            dv_sr <= {dv_sr[2:0], din_dv};
            sy_sr <= {sy_sr[2:0], sync_in};
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            chk("dv_align", dout_dv, dv_sr[3]);
            chk("sync_align", sync_out, sy_sr[3]);
            if (dout_dv === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", cyc, e.cyc);
                    chk("chn", dout_chn, e.chn);
                    chk("dp1", dout_dp1, e.dp1);
                    chk("dp2", dout_dp2, e.dp2);
                end
            end
        end
    end

    task automatic drive(input bit dv, input int ch, input int x, input bit dir,
                         input int e1, input int e2);
        exp_t e;
        int   c;
        @(posedge clk);
        #1;
        din_dv  = dv;
        din_chn = 8'(ch);
        din_dq  = 16'(x);
        sync_in = 1'($urandom_range(0, 1));
        if (dv) begin
            c     = ch % 16;
            e.chn = 8'(ch);
            e.dp1 = dir ? e1 : mh[c][0];
            e.dp2 = dir ? e2 : model_dp2(x, mh[c][0], mh[c][1], mh[c][2]);
            e.cyc = cyc + 4;
            sb.push_back(e);
            mh[c][2] = mh[c][1];
            mh[c][1] = mh[c][0];
            mh[c][0] = x;
        end
    endtask

    task automatic send(input int ch, input int x);
        drive(1'b1, ch, x, 1'b0, 0, 0);
    endtask

    task automatic sendx(input int ch, input int x, input int e1, input int e2);
        drive(1'b1, ch, x, 1'b1, e1, e2);
    endtask

    // Idle cycles carry random data and tags that must not touch history.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, $urandom_range(0, 255), $urandom_range(0, 65535) - 32768, 1'b0, 0, 0);
    endtask

    task automatic clear_model();
        for (int c = 0; c < 16; c++)
            for (int k = 0; k < 3; k++) mh[c][k] = 0;
    endtask

    task automatic chk_zero_out(input string pfx);
        chk({pfx, "_dp1"}, dout_dp1, 0);
        chk({pfx, "_dp2"}, dout_dp2, 0);
        chk({pfx, "_dv"},  dout_dv,  0);
        chk({pfx, "_chn"}, dout_chn, 0);
        chk({pfx, "_sync"}, sync_out, 0);
    endtask

    task automatic impulse(input int ch);
        for (int i = 0; i < 5; i++) sendx(ch, imp_x[i], imp_p1[i], imp_p2[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, i1;
        clear_model();
        rst_n   = 1'b0;
        din_dq  = '0;
        din_dv  = 1'b0;
        din_chn = '0;
        sync_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_out("rst");
        rst_n = 1'b1;
        idle(2);

        // Impulse on ch3, continuous dv
        impulse(3);
        idle(6);

        // DC full-scale on ch0: first three from model, then steady state
        for (int i = 0; i < 8; i++) begin
            if (i < 3) send(0, 32767);
            else       sendx(0, 32767, 32767, 32766);
        end
        idle(5);

        // Saturation on ch0
        send(0, -32768);
        send(0, 32767);
        send(0, 32767);
        sendx(0, -32768, 32767, 32767);
        idle(5);

        // Flush ch0 history, then interleave ch0 impulse / ch1 DC with gaps
        send(0, 0); send(0, 0); send(0, 0);
        i0 = 0; i1 = 0;
        while (i0 < 5 || i1 < 6) begin
            if (i0 < 5 && (i1 >= 6 || $urandom_range(0, 1) == 1)) begin
                sendx(0, imp_x[i0], imp_p1[i0], imp_p2[i0]);
                i0++;
            end else begin
                send(1, 1000);
                i1++;
            end
            idle($urandom_range(0, 2));
        end
        idle(5);

        // Back-to-back same channel
        impulse(5);
        idle(5);

        // Tag aliasing: 0xF3 shares ch3 history, full tag comes back
        send(3, 12345);
        send(8'hF3, -2222);
        send(8'h23, 777);
        send(3, -30000);
        idle(5);

        // Random mixed traffic across all channels, model-checked
        for (int i = 0; i < 40; i++) begin
            send($urandom_range(0, 255), $urandom_range(0, 65535) - 32768);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(6);
        chk("sb_drain1", sb.size(), 0);

        // Reset mid-impulse on ch6
        sendx(6, 16384, 0, -1033);
        send(6, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        din_dv = 1'b0;
        sb.delete();
        clear_model();
        #1;
        chk_zero_out("mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(6);
        impulse(6);
        idle(6);
        chk("sb_drain2", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tst, n_err);
        $finish;
    end

endmodule
